sync_fifo_param: RTL

- Parametrised synchronous FIFO; next generation of the 16-bit, 8-deep buffer used between the sequence-mapping pipeline stages.
- Adds the following:
  - configurable width and depth
  - programmable almost-full / almost-empty thresholds
  - optional first-word-fall-through (FWFT) read mode
  - write-while-full when a read is accepted in the same cycle
  - sticky overflow/underflow error flags
- Single clock domain. Sits between the seed-extraction stage and the comparator array.

---
 rtl/sync_fifo_param.sv | 117 +++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised synchronous FIFO with thresholds, FWFT option and sticky error flags
module sync_fifo_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int AF_LVL = (2**ADDR_W) - 2,
  parameter int AE_LVL = 2,
  parameter bit FWFT   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] buf_in,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] buf_out,
  output logic              rd_valid,
  output logic              buf_empty,
  output logic              buf_full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   fifo_counter,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W+1)'(AF_LVL);
  localparam logic [ADDR_W:0] AE_CNT    = (ADDR_W+1)'(AE_LVL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_acc;
  logic              wr_acc;

  // A full FIFO still takes a write when a read frees a slot in the same cycle;
  // an empty FIFO never bypasses, so a read there is simply refused.
  assign rd_acc = rd_en && !buf_empty;
  assign wr_acc = wr_en && (!buf_full || rd_acc);

  // Flags decode the registered occupancy, so they move one cycle after the accepting edge.
  assign buf_empty    = (fifo_counter == '0);
  assign buf_full     = (fifo_counter == DEPTH_CNT);
  assign almost_full  = (fifo_counter >= AF_CNT);
  assign almost_empty = (fifo_counter <= AE_CNT);

  // Storage array; contents survive reset and are only ever overwritten by accepted writes.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= buf_in;
    end
  end

  // Pointers advance on their own accept and wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy tracks net accepted traffic; simultaneous accepts leave it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_counter <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   fifo_counter <= fifo_counter + 1'b1;
        2'b01:   fifo_counter <= fifo_counter - 1'b1;
        default: fifo_counter <= fifo_counter;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle takes priority over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_acc) overflow <= 1'b1;
      else if (clr_err)     overflow <= 1'b0;
      if (rd_en && buf_empty) underflow <= 1'b1;
      else if (clr_err)       underflow <= 1'b0;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is always presented; rd_en only pops it.
      assign buf_out  = mem[rd_ptr];
      assign rd_valid = !buf_empty;
    end else begin : g_reg
      logic [DATA_W-1:0] out_q;
      logic              valid_q;

      // Registered read: data lands one cycle after an accepted read and is held otherwise.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_q   <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) out_q <= mem[rd_ptr];
        end
      end

      assign buf_out  = out_q;
      assign rd_valid = valid_q;
    end
  endgenerate

endmodule
